// File: rtl/regressor_tap_buffer.sv
// regressor_tap_buffer
// Keeps a circular history of the last NUM_TAPS normalized samples. After each
// accepted sample it streams the regressor vector x[n], x[n-1], ...,
// x[n-NUM_TAPS+1] to the MAC stage, one tap per valid/ready handshake.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   in_valid/in_ready sample handshake (in_ready is combinational)
//   in_sample         signed normalized sample
//   flush             clear history and abort any stream in progress
//   tap_valid/ready   tap handshake towards the MAC stage
//   tap_data          tap value x[n-k]
//   tap_index         k, 0 = newest
//   tap_last          high with k = NUM_TAPS-1
//   fill_count        valid history entries, saturates at NUM_TAPS
//   primed            fill_count == NUM_TAPS
//   stall_count       (REGRESSOR_TAP_BUFFER_STALL_CNT_EN only) saturating count
//                     of cycles with tap_valid & !tap_ready; cleared by reset only
//
// Optional feature macro: REGRESSOR_TAP_BUFFER_STALL_CNT_EN

module regressor_tap_buffer #(
  parameter  int unsigned DATA_W   = 16,
  parameter  int unsigned NUM_TAPS = 8,
  localparam int unsigned IDX_W    = $clog2(NUM_TAPS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_sample,
  input  logic                     flush,
  output logic                     tap_valid,
  input  logic                     tap_ready,
  output logic signed [DATA_W-1:0] tap_data,
  output logic        [IDX_W-1:0]  tap_index,
  output logic                     tap_last,
  output logic        [IDX_W:0]    fill_count,
  output logic                     primed
`ifdef REGRESSOR_TAP_BUFFER_STALL_CNT_EN
  ,
  output logic        [15:0]       stall_count
`endif
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TAPS - 1);
  localparam logic [IDX_W:0]   FULL_CNT = (IDX_W+1)'(NUM_TAPS);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  state_e                    state_q, state_d;
  logic signed [DATA_W-1:0]  hist_q [NUM_TAPS];
  logic signed [DATA_W-1:0]  hist_d [NUM_TAPS];
  logic        [IDX_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic        [IDX_W:0]     fill_count_q, fill_count_d;
  logic                      primed_q, primed_d;
  logic                      tap_valid_q, tap_valid_d;
  logic signed [DATA_W-1:0]  tap_data_q, tap_data_d;
  logic        [IDX_W-1:0]   tap_index_q, tap_index_d;
  logic                      tap_last_q, tap_last_d;
  logic        [IDX_W-1:0]   rd_ptr;

  // Entry for the next tap k+1: newest sits at wr_ptr-1, so x[n-(k+1)] is at
  // wr_ptr - k - 2 (natural IDX_W-bit wrap).
  assign rd_ptr = wr_ptr_q - tap_index_q - IDX_W'(2);

  assign in_ready = (state_q == IDLE) & ~flush;

  // Next-state and datapath update
  always_comb begin
    state_d      = state_q;
    hist_d       = hist_q;
    wr_ptr_d     = wr_ptr_q;
    fill_count_d = fill_count_q;
    tap_valid_d  = tap_valid_q;
    tap_data_d   = tap_data_q;
    tap_index_d  = tap_index_q;

    if (flush) begin
      // Flush wins over any simultaneous input or tap handshake
      hist_d       = '{default: '0};
      wr_ptr_d     = '0;
      fill_count_d = '0;
      tap_valid_d  = 1'b0;
      state_d      = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            hist_d[wr_ptr_q] = in_sample;
            wr_ptr_d         = wr_ptr_q + IDX_W'(1);
            if (fill_count_q != FULL_CNT) begin
              fill_count_d = fill_count_q + (IDX_W+1)'(1);
            end
            // First tap bypasses the history so it is valid next cycle
            tap_data_d  = in_sample;
            tap_index_d = '0;
            tap_valid_d = 1'b1;
            state_d     = STREAM;
          end
        end
        STREAM: begin
          if (tap_valid_q && tap_ready) begin
            if (tap_index_q == LAST_IDX) begin
              tap_valid_d = 1'b0;
              state_d     = IDLE;
            end else begin
              tap_index_d = tap_index_q + IDX_W'(1);
              tap_data_d  = hist_q[rd_ptr];
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    tap_last_d = tap_valid_d & (tap_index_d == LAST_IDX);
    primed_d   = (fill_count_d == FULL_CNT);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      hist_q       <= '{default: '0};
      wr_ptr_q     <= '0;
      fill_count_q <= '0;
      primed_q     <= 1'b0;
      tap_valid_q  <= 1'b0;
      tap_data_q   <= '0;
      tap_index_q  <= '0;
      tap_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      hist_q       <= hist_d;
      wr_ptr_q     <= wr_ptr_d;
      fill_count_q <= fill_count_d;
      primed_q     <= primed_d;
      tap_valid_q  <= tap_valid_d;
      tap_data_q   <= tap_data_d;
      tap_index_q  <= tap_index_d;
      tap_last_q   <= tap_last_d;
    end
  end

  assign tap_valid  = tap_valid_q;
  assign tap_data   = tap_data_q;
  assign tap_index  = tap_index_q;
  assign tap_last   = tap_last_q;
  assign fill_count = fill_count_q;
  assign primed     = primed_q;

`ifdef REGRESSOR_TAP_BUFFER_STALL_CNT_EN
  logic [15:0] stall_count_q, stall_count_d;

  // Saturating backpressure counter; survives flush
  always_comb begin
    stall_count_d = stall_count_q;
    if (tap_valid_q && !tap_ready && (stall_count_q != 16'hFFFF)) begin
      stall_count_d = stall_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_regressor_tap_buffer.sv
// Directed bench for regressor_tap_buffer with NUM_TAPS=4, DATA_W=16.
module tb_regressor_tap_buffer;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned NUM_TAPS = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_sample;
  logic              flush;
  logic              tap_valid;
  logic              tap_ready;
  logic [DATA_W-1:0] tap_data;
  logic [1:0]        tap_index;
  logic              tap_last;
  logic [2:0]        fill_count;
  logic              primed;
`ifdef REGRESSOR_TAP_BUFFER_STALL_CNT_EN
  logic [15:0]       stall_count;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  regressor_tap_buffer #(
    .DATA_W   (DATA_W),
    .NUM_TAPS (NUM_TAPS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sample  (in_sample),
    .flush      (flush),
    .tap_valid  (tap_valid),
    .tap_ready  (tap_ready),
    .tap_data   (tap_data),
    .tap_index  (tap_index),
    .tap_last   (tap_last),
    .fill_count (fill_count),
    .primed     (primed)
`ifdef REGRESSOR_TAP_BUFFER_STALL_CNT_EN
    ,
    .stall_count(stall_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one sample once in_ready is seen; returns one cycle after the handshake
  task automatic send(input logic [15:0] s);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    chk("send_in_ready", 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    in_sample = s;
    step();
    in_valid  = 1'b0;
  endtask

  // With tap_ready high, expect d0..d3 on consecutive cycles then an idle cycle
  task automatic drain(input logic [15:0] d0, input logic [15:0] d1,
                       input logic [15:0] d2, input logic [15:0] d3);
    logic [15:0] e [4];
    e[0] = d0; e[1] = d1; e[2] = d2; e[3] = d3;
    tap_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("drain_valid", 32'(tap_valid), 32'd1);
      chk("drain_index", 32'(tap_index), 32'(k));
      chk("drain_data",  32'(tap_data),  32'(e[k]));
      chk("drain_last",  32'(tap_last),  32'(k == 3));
      step();
    end
    chk("drain_end_valid", 32'(tap_valid), 32'd0);
    chk("drain_end_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sample = '0;
    flush     = 1'b0;
    tap_ready = 1'b0;

    // Reset with random inputs
    for (int i = 0; i < 3; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_sample = 16'($urandom);
      flush     = 1'($urandom_range(0, 1));
      tap_ready = 1'($urandom_range(0, 1));
      step();
    end
    chk("rst_tap_valid", 32'(tap_valid), 32'd0);
    chk("rst_tap_data",  32'(tap_data),  32'd0);
    chk("rst_tap_index", 32'(tap_index), 32'd0);
    chk("rst_tap_last",  32'(tap_last),  32'd0);
    chk("rst_fill",      32'(fill_count), 32'd0);
    chk("rst_primed",    32'(primed),    32'd0);
`ifdef REGRESSOR_TAP_BUFFER_STALL_CNT_EN
    chk("rst_stall",     32'(stall_count), 32'd0);
`endif
    rst_n    = 1'b1;
    in_valid = 1'b0;
    flush    = 1'b0;
    tap_ready = 1'b1;
    step();
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Partial fill: zero-padded regressor
    send(16'h0100);
    chk("first_tap_latency", 32'(tap_valid), 32'd1);
    drain(16'h0100, 16'h0000, 16'h0000, 16'h0000);
    chk("partial_fill", 32'(fill_count), 32'd1);
    chk("partial_primed", 32'(primed), 32'd0);

    // Clear history before the wrap sequence
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_idle_fill", 32'(fill_count), 32'd0);

    // Wrap: samples 1..5
    send(16'd1); drain(16'd1, 16'd0, 16'd0, 16'd0);
    chk("wrap_fill1", 32'(fill_count), 32'd1);
    send(16'd2); drain(16'd2, 16'd1, 16'd0, 16'd0);
    send(16'd3); drain(16'd3, 16'd2, 16'd1, 16'd0);
    chk("wrap_primed3", 32'(primed), 32'd0);
    send(16'd4); drain(16'd4, 16'd3, 16'd2, 16'd1);
    chk("wrap_fill4",   32'(fill_count), 32'd4);
    chk("wrap_primed4", 32'(primed), 32'd1);
    send(16'd5); drain(16'd5, 16'd4, 16'd3, 16'd2);
    chk("wrap_fill5",   32'(fill_count), 32'd4);
    chk("wrap_primed5", 32'(primed), 32'd1);

    // Backpressure at tap_index 1 with a competing input sample
    send(16'd6);
    chk("bp_idx0_data", 32'(tap_data), 32'd6);
    step();
    chk("bp_idx1", 32'(tap_index), 32'd1);
    tap_ready = 1'b0;
    in_valid  = 1'b1;
    in_sample = 16'h7FFF;
    #1;
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_valid", 32'(tap_valid), 32'd1);
      chk("bp_index", 32'(tap_index), 32'd1);
      chk("bp_data",  32'(tap_data),  32'd5);
      chk("bp_last",  32'(tap_last),  32'd0);
      chk("bp_in_ready_hold", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    tap_ready = 1'b1;
    step();
    chk("bp_idx2_data", 32'(tap_data), 32'd4);
    step();
    chk("bp_idx3_data", 32'(tap_data), 32'd3);
    chk("bp_idx3_last", 32'(tap_last), 32'd1);
    step();
    chk("bp_end_valid", 32'(tap_valid), 32'd0);
    send(16'd8); drain(16'd8, 16'd6, 16'd5, 16'd4);

    // Flush mid-stream at tap_index 2
    send(16'd9);
    step();
    step();
    chk("fl_idx2", 32'(tap_index), 32'd2);
    chk("fl_idx2_data", 32'(tap_data), 32'd6);
    flush = 1'b1;
    #1;
    chk("fl_in_ready_low", 32'(in_ready), 32'd0);
    step();
    flush = 1'b0;
    #1;
    chk("fl_valid",    32'(tap_valid), 32'd0);
    chk("fl_last",     32'(tap_last),  32'd0);
    chk("fl_fill",     32'(fill_count), 32'd0);
    chk("fl_primed",   32'(primed),    32'd0);
    chk("fl_in_ready", 32'(in_ready),  32'd1);
    send(16'h0007); drain(16'h0007, 16'd0, 16'd0, 16'd0);

`ifdef REGRESSOR_TAP_BUFFER_STALL_CNT_EN
    // Stall counter: 5 stalls, flush, 2 stalls -> 7
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("stall_rst", 32'(stall_count), 32'd0);
    tap_ready = 1'b0;
    send(16'h0011);
    for (int i = 0; i < 5; i++) step();
    chk("stall_5", 32'(stall_count), 32'd5);
    tap_ready = 1'b1;
    flush     = 1'b1;
    step();
    flush     = 1'b0;
    tap_ready = 1'b0;
    chk("stall_after_flush", 32'(stall_count), 32'd5);
    send(16'h0012);
    step();
    step();
    chk("stall_7", 32'(stall_count), 32'd7);
    tap_ready = 1'b1;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
